multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum consecutive memory wait cycles before a timeout fault; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instr  input  32  instruction register contents; opcode is instr[31:26], funct is instr[5:0].
REQ-005 mem_ready  input  1  memory completion for the current request.
REQ-006 mem_req  output  1  memory access request.
REQ-007 iord  output  1  memory address select: 0 = PC, 1 = ALU output register.
REQ-008 mem_write, ir_write, pc_write, branch, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and selects.
REQ-009 alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-010 pc_src  output  2  PC source select: 00 = ALU, 01 = ALU output register, 10 = jump target.
REQ-011 alucontrol  output  3  ALU operation code.
REQ-012 err  output  1  sticky fault flag.

Function
REQ-013 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT.
REQ-014 Every output SHALL be 0 in any state that does not explicitly assert it.
REQ-015 FETCH SHALL drive mem_req=1, iord=0, alu_src_b=01, ALU add, and pc_src=00.
REQ-015a In FETCH, ir_write and pc_write SHALL be 1 only in the cycle where mem_ready=1.
REQ-015b FETCH SHALL advance to DECODE on mem_ready=1 and otherwise hold.
REQ-016 DECODE SHALL drive alu_src_b=11 with ALU add.
REQ-016a DECODE SHALL branch on opcode: 100011 or 101011 to MEMADR, 000000 to RTYPEEX, 000100 to BEQEX, 001000 to ADDIEX, 000010 to JEX.
REQ-016b Any other opcode in DECODE SHALL go to HALT and set err.
REQ-017 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, ALU add; it SHALL go to MEMRD when the opcode is lw and to MEMWR when it is sw.
REQ-018 MEMRD SHALL drive mem_req=1 and iord=1, holding until mem_ready=1 and then going to MEMWB.
REQ-018a MEMWB SHALL drive reg_write=1 and mem_to_reg=1, then go to FETCH.
REQ-019 MEMWR SHALL drive mem_req=1, iord=1 and mem_write=1, holding until mem_ready=1 and then going to FETCH.
REQ-020 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00, funct-decoded ALU op, then go to RTYPEWB.
REQ-020a RTYPEWB SHALL drive reg_write=1 and reg_dst=1, then go to FETCH.
REQ-021 BEQEX SHALL drive alu_src_a=1, alu_src_b=00, ALU sub, pc_src=01 and branch=1, then go to FETCH.
REQ-022 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, ALU add, then go to ADDIWB.
REQ-022a ADDIWB SHALL drive reg_write=1, then go to FETCH.
REQ-023 JEX SHALL drive pc_src=10 and pc_write=1, then go to FETCH.
REQ-024 alucontrol encodings SHALL be: add=010, sub=110.
REQ-024a In RTYPEEX, funct SHALL map as 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111; any other funct SHALL map to 010.
REQ-025 Zero-wait cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-026 An 8-bit wait counter SHALL increment on each cycle with mem_req=1 and mem_ready=0, and clear on mem_ready=1 or on any state change.
REQ-027 When the wait counter reaches WAIT_LIMIT while mem_ready=0, the next state SHALL be HALT and err SHALL set.
REQ-027a mem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-028 HALT SHALL drive all strobes to 0, hold err=1, and leave only on reset.
REQ-029 instr SHALL be sampled only in DECODE and in the execute states; instr changes in FETCH SHALL not affect outputs.

Reset
REQ-030 rst_n=0 SHALL immediately force state FETCH, wait counter 0, err 0, independent of clk.
REQ-031 Reset asserted during MEMWR SHALL deassert mem_write in the same cycle without waiting for a clock edge.
REQ-032 The first FETCH request SHALL be issued in the first cycle after rst_n rises.

Configuration
REQ-033 With macro MULTICYCLE_BNE_EN defined, opcode 000101 (bne) SHALL go from DECODE to state BNEEX.
REQ-033a BNEEX SHALL match BEQEX except that it drives branch=0 and an added output branch_ne=1.
REQ-034 Without MULTICYCLE_BNE_EN, opcode 000101 SHALL be illegal (go to HALT, err=1), and port branch_ne SHALL not exist.

Verification
REQ-035 Reset, then lw (instr=0x8C080004) with mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 in cycle 5; back in FETCH at cycle 6.
REQ-036 R-type sub (funct 100010) -> alucontrol=110 in RTYPEEX; reg_write=1 with reg_dst=1 in the next cycle.
REQ-037 sw with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles; FETCH follows the ready cycle.
REQ-038 WAIT_LIMIT=4 with mem_ready stuck 0 in FETCH -> HALT and err=1 after 4 wait cycles; all strobes 0 until rst_n pulses low.
REQ-039 Opcode 111111 -> HALT with err=1 after DECODE; opcode 000101 -> BNEEX only when MULTICYCLE_BNE_EN is defined.
REQ-040 rst_n pulsed low mid-MEMWR -> mem_write=0 asynchronously; state FETCH with err=0 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS-style control FSM with memory wait timeout.
// Defining MULTICYCLE_BNE_EN adds the bne opcode, the BNEEX state and the branch_ne port.
module multicycle_controller #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        iord,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        branch,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic [2:0]  alucontrol,
`ifdef MULTICYCLE_BNE_EN
   output logic        branch_ne,
`endif
   output logic        err
);
   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] RTYPEEX = 4'd6;
   localparam logic [3:0] RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
   localparam logic [3:0] JEX     = 4'd11;
   localparam logic [3:0] HALT    = 4'd12;
`ifdef MULTICYCLE_BNE_EN
   localparam logic [3:0] BNEEX   = 4'd13;
   localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;

   logic [3:0] state_q, state_d, dec_state;
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;
   logic [5:0] op;
   logic [2:0] rtype_alu;
   logic       wait_cyc, timeout;
   logic       unused_instr;

   assign op           = instr[31:26];
   assign unused_instr = ^instr[25:6];
   assign wait_cyc     = mem_req && !mem_ready;
   // The counter must already hold WAIT_LIMIT, so a late ready on that cycle still wins.
   assign timeout      = wait_cyc && (wait_q == 8'(WAIT_LIMIT));

   always_comb begin
      case (op)
         OP_LW, OP_SW: dec_state = MEMADR;
         OP_RTYPE:     dec_state = RTYPEEX;
         OP_BEQ:       dec_state = BEQEX;
         OP_ADDI:      dec_state = ADDIEX;
         OP_J:         dec_state = JEX;
`ifdef MULTICYCLE_BNE_EN
         OP_BNE:       dec_state = BNEEX;
`endif
         default:      dec_state = HALT;
      endcase
   end

   always_comb begin
      case (instr[5:0])
         6'b100010: rtype_alu = 3'b110;
         6'b100100: rtype_alu = 3'b000;
         6'b100101: rtype_alu = 3'b001;
         6'b101010: rtype_alu = 3'b111;
         default:   rtype_alu = 3'b010;
      endcase
   end

   always_comb begin
      case (state_q)
         FETCH:   state_d = mem_ready ? DECODE : FETCH;
         DECODE:  state_d = dec_state;
         MEMADR:  state_d = op == OP_LW ? MEMRD : op == OP_SW ? MEMWR : HALT;
         MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
         MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state_d = FETCH;
`ifdef MULTICYCLE_BNE_EN
         BNEEX:   state_d = FETCH;
`endif
         default: state_d = HALT;
      endcase
      if (timeout) state_d = HALT;
   end

   assign wait_d = (state_d != state_q || !wait_cyc) ? 8'd0 : wait_q + 8'd1;
   assign err_d  = err_q || state_d == HALT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alucontrol = 3'b000;
`ifdef MULTICYCLE_BNE_EN
      branch_ne  = 1'b0;
`endif
      case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            alu_src_b  = 2'b01;
            alucontrol = ALU_ADD;
         end
         DECODE: begin
            alu_src_b  = 2'b11;
            alucontrol = ALU_ADD;
         end
         MEMADR, ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alucontrol = ALU_ADD;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         RTYPEEX: begin
            alu_src_a  = 1'b1;
            alucontrol = rtype_alu;
         end
         RTYPEWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BEQEX: begin
            alu_src_a  = 1'b1;
            alucontrol = ALU_SUB;
            pc_src     = 2'b01;
            branch     = 1'b1;
         end
`ifdef MULTICYCLE_BNE_EN
         BNEEX: begin
            alu_src_a  = 1'b1;
            alucontrol = ALU_SUB;
            pc_src     = 2'b01;
            branch_ne  = 1'b1;
         end
`endif
         ADDIWB: reg_write = 1'b1;
         JEX: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign err = err_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams with random memory latency,
// checked against a per-instruction step sequence model built from the control table.
module tb_multicycle_controller;
   localparam int WL = 4;

   typedef enum {K_F, K_D, K_MA, K_MR, K_MWB, K_MW, K_RX, K_RW, K_BQ, K_BN, K_AX, K_AW, K_J, K_H} kind_e;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        mem_ready;
   logic        mem_req, iord, mem_write, ir_write, pc_write, branch;
   logic        reg_write, reg_dst, mem_to_reg, alu_src_a, err, bne_o;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alucontrol;
   logic [18:0] obs;
   int          n_tests = 0;
   int          n_fail = 0;
   int          mw_cnt = 0;

   multicycle_controller #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .pc_write(pc_write), .branch(branch), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_src(pc_src), .alucontrol(alucontrol),
`ifdef MULTICYCLE_BNE_EN
      .branch_ne(bne_o),
`endif
      .err(err)
   );
`ifndef MULTICYCLE_BNE_EN
   assign bne_o = 1'b0;
`endif

   assign obs = {mem_req, iord, mem_write, ir_write, pc_write, branch, bne_o, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alucontrol, err};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      if (fn == 6'd32) return 3'd2;
      if (fn == 6'd34) return 3'd6;
      if (fn == 6'd36) return 3'd0;
      if (fn == 6'd37) return 3'd1;
      if (fn == 6'd42) return 3'd7;
      return 3'd2;
   endfunction

   function automatic logic [18:0] exp_vec(input kind_e k, input logic rdy, input logic [5:0] fn);
      logic mreq = 0, io = 0, mwr = 0, irw = 0, pcw = 0, br = 0, brn = 0, rw = 0;
      logic rd = 0, m2r = 0, asa = 0, er = 0;
      logic [1:0] asb = 0, ps = 0;
      logic [2:0] alu = 0;
      case (k)
         K_F:  begin mreq = 1; irw = rdy; pcw = rdy; asb = 1; alu = 2; end
         K_D:  begin asb = 3; alu = 2; end
         K_MA, K_AX: begin asa = 1; asb = 2; alu = 2; end
         K_MR: begin mreq = 1; io = 1; end
         K_MWB: begin rw = 1; m2r = 1; end
         K_MW: begin mreq = 1; io = 1; mwr = 1; end
         K_RX: begin asa = 1; alu = funct_alu(fn); end
         K_RW: begin rw = 1; rd = 1; end
         K_BQ: begin asa = 1; alu = 6; ps = 1; br = 1; end
         K_BN: begin asa = 1; alu = 6; ps = 1; brn = 1; end
         K_AW: rw = 1;
         K_J:  begin ps = 2; pcw = 1; end
         default: er = 1;
      endcase
      return {mreq, io, mwr, irw, pcw, br, brn, rw, rd, m2r, asa, asb, ps, alu, er};
   endfunction

   task automatic step_chk(input kind_e k, input logic r, input logic [31:0] ins);
      mem_ready = r;
      instr = ins;
      #3;
      chk(k.name(), 32'(obs), 32'(exp_vec(k, r, ins[5:0])));
      if (mem_write) mw_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #2;
      chk("rst_async", 32'(obs), 32'(exp_vec(K_F, 1'b0, 6'd0)));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // A memory step lasts until ready; ready arriving on cycle index WL still completes it.
   task automatic mem_step(input kind_e k, input int w, input logic [31:0] ins, output bit halted);
      bit done = 0;
      for (int c = 0; c <= WL && !done; c++) begin
         step_chk(k, c == w, k == K_F ? $urandom : ins);
         done = (c == w);
      end
      halted = !done;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
      kind_e seq[$];
      bit halted;
      case (ins[31:26])
         6'h23:   seq = {K_D, K_MA, K_MR, K_MWB};
         6'h2b:   seq = {K_D, K_MA, K_MW};
         6'h00:   seq = {K_D, K_RX, K_RW};
         6'h04:   seq = {K_D, K_BQ};
         6'h08:   seq = {K_D, K_AX, K_AW};
         6'h02:   seq = {K_D, K_J};
`ifdef MULTICYCLE_BNE_EN
         6'h05:   seq = {K_D, K_BN};
`endif
         default: seq = {K_D, K_H};
      endcase
      mem_step(K_F, fw, ins, halted);
      foreach (seq[i]) begin
         if (halted) break;
         if (seq[i] == K_H) halted = 1;
         else if (seq[i] == K_MR || seq[i] == K_MW) mem_step(seq[i], mw, ins, halted);
         else step_chk(seq[i], 1'($urandom_range(0, 1)), ins);
      end
      if (halted) begin
         repeat (3) step_chk(K_H, 1'($urandom_range(0, 1)), $urandom);
         pulse_reset();
      end
   endtask

   function automatic int rand_wait();
      return $urandom_range(0, 9) == 0 ? WL + 1 : $urandom_range(0, WL);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops[7] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05};
      logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      rst_n = 1'b0;
      mem_ready = 1'b0;
      instr = 32'h0;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_hold", 32'(obs), 32'(exp_vec(K_F, 1'b0, 6'd0)));
      rst_n = 1'b1;
      run_instr(32'h8C080004, 0, 0);
      run_instr(32'h012A4022, 0, 0);
      mw_cnt = 0;
      run_instr(32'hAD280008, 0, 3);
      chk("sw_mw_cycles", 32'(mw_cnt), 32'd4);
      run_instr(32'h8C080004, WL, WL);
      run_instr(32'h11090003, 1, 0);
      run_instr(32'h21290005, 2, 0);
      run_instr(32'h08000010, 0, 0);
      run_instr(32'h8C080004, WL + 1, 0);
      run_instr(32'h8C080004, 0, WL + 1);
      run_instr(32'hFC000000, 0, 0);
      run_instr(32'h15090002, 0, 0);
      step_chk(K_F, 1'b1, $urandom);
      step_chk(K_D, 1'b0, 32'hAD280008);
      step_chk(K_MA, 1'b0, 32'hAD280008);
      step_chk(K_MW, 1'b0, 32'hAD280008);
      mem_ready = 1'b0;
      #1;
      chk("mw_before_rst", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mw_async_drop", 32'(mem_write), 32'd0);
      chk("mw_rst_state", 32'(obs), 32'(exp_vec(K_F, 1'b0, 6'd0)));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 80; i++) begin
         logic [31:0] ins = $urandom;
         int sel = $urandom_range(0, 7);
         ins[31:26] = sel == 7 ? 6'($urandom_range(0, 63)) : ops[sel];
         if ($urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 4)];
         run_instr(ins, rand_wait(), rand_wait());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
